// File: rtl/vsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : vsm_sequencer
//  Purpose  : Job sequencer feeding column/scalar pairs to the vector-scalar
//             MAC array and capturing its output vector.
//  Revision : 1.0 - initial release
// ============================================================================
module vsm_sequencer #(
   parameter int SIZE          = 6,
   parameter int WIDTH         = 8,
   parameter int ACCUMULATIONS = 3,
   parameter int ADDR_W        = 2,
   parameter int DRAIN_CYCLES  = 2
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  wr_en,
   input  logic                  wr_sel,
   input  logic [ADDR_W-1:0]     wr_addr,
   input  logic [8*SIZE-1:0]     wr_data,
   input  logic                  start,
   output logic                  busy,
   output logic                  mac_clear,
   output logic                  vsm_enable,
   output logic [8*SIZE-1:0]     vsm_a,
   output logic [7:0]            vsm_b,
   input  logic [8*SIZE-1:0]     result_in,
   output logic [8*SIZE-1:0]     result,
   output logic                  done
);

   localparam int                C_DEPTH      = 2**ADDR_W;
   localparam int                C_CNT_W      = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [ADDR_W:0]   C_ACC        = (ADDR_W+1)'(ACCUMULATIONS);
   localparam logic [ADDR_W-1:0] C_LAST       = ADDR_W'(ACCUMULATIONS-1);
   localparam logic [C_CNT_W-1:0] C_DRAIN_LOAD = C_CNT_W'(DRAIN_CYCLES-1);

   if ((ACCUMULATIONS < 1) || (C_DEPTH < ACCUMULATIONS) || (DRAIN_CYCLES < 1) ||
       (WIDTH < 1) || (SIZE < 1)) begin : g_bad_params
      $error("vsm_sequencer: illegal parameter set");
   end

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_CLEAR   = 3'd1,
      S_RUN     = 3'd2,
      S_DRAIN   = 3'd3,
      S_CAPTURE = 3'd4
   } state_t;

   state_t               r_state;
   state_t               w_next;
   logic [ADDR_W-1:0]    r_index;
   logic [C_CNT_W-1:0]   r_cnt;
   logic [8*SIZE-1:0]    r_result;
   logic                 r_done;
   logic [8*SIZE-1:0]    r_col    [C_DEPTH];
   logic [7:0]           r_scalar [C_DEPTH];
   logic                 w_wr_ok;

   assign w_wr_ok = (r_state == S_IDLE) && wr_en && ({1'b0, wr_addr} < C_ACC);
   assign busy    = (r_state != S_IDLE);
   assign result  = r_result;
   assign done    = r_done;

   // Buffers are frozen outside IDLE so a running job sees a stable operand set.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < C_DEPTH; i++) begin
            r_col[i]    <= '0;
            r_scalar[i] <= '0;
         end
      end else if (w_wr_ok) begin
         if (wr_sel) begin
            r_scalar[wr_addr] <= wr_data[7:0];
         end else begin
            r_col[wr_addr] <= wr_data;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state  <= S_IDLE;
         r_index  <= '0;
         r_cnt    <= '0;
         r_result <= '0;
         r_done   <= 1'b0;
      end else begin
         r_state <= w_next;
         r_done  <= (r_state == S_CAPTURE);
         case (r_state)
            S_CLEAR: r_index <= '0;
            S_RUN: begin
               r_index <= r_index + ADDR_W'(1);
               if (r_index == C_LAST) begin
                  r_cnt <= C_DRAIN_LOAD;
               end
            end
            S_DRAIN: begin
               if (r_cnt != '0) begin
                  r_cnt <= r_cnt - C_CNT_W'(1);
               end
            end
            S_CAPTURE: r_result <= result_in;
            default: ;
         endcase
      end
   end

   always_comb begin
      w_next     = r_state;
      mac_clear  = 1'b0;
      vsm_enable = 1'b0;
      vsm_a      = '0;
      vsm_b      = '0;
      case (r_state)
         S_IDLE: begin
            if (start) begin
               w_next = S_CLEAR;
            end
         end
         S_CLEAR: begin
            mac_clear = 1'b1;
            w_next    = S_RUN;
         end
         S_RUN: begin
            vsm_enable = 1'b1;
            vsm_a      = r_col[r_index];
            vsm_b      = r_scalar[r_index];
            if (r_index == C_LAST) begin
               w_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (r_cnt == '0) begin
               w_next = S_CAPTURE;
            end
         end
         S_CAPTURE: w_next = S_IDLE;
         default:   w_next = S_IDLE;
      endcase
   end

endmodule
`default_nettype wire

// File: tb/tb_vsm_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vsm_sequencer
//  Purpose  : Directed self-checking bench for vsm_sequencer.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vsm_sequencer;

   logic        clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic        wr_sel;
   logic [1:0]  wr_addr;
   logic [47:0] wr_data;
   logic        start;
   logic        busy;
   logic        mac_clear;
   logic        vsm_enable;
   logic [47:0] vsm_a;
   logic [7:0]  vsm_b;
   logic [47:0] result_in;
   logic [47:0] result;
   logic        done;

   int checks   = 0;
   int failures = 0;

   logic [47:0] exp_a [3];
   logic [7:0]  exp_b [3];

   always #5 clk = ~clk;

   vsm_sequencer #(
      .SIZE(6), .WIDTH(8), .ACCUMULATIONS(3), .ADDR_W(2), .DRAIN_CYCLES(2)
   ) dut (
      .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel), .wr_addr(wr_addr),
      .wr_data(wr_data), .start(start), .busy(busy), .mac_clear(mac_clear),
      .vsm_enable(vsm_enable), .vsm_a(vsm_a), .vsm_b(vsm_b), .result_in(result_in),
      .result(result), .done(done)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic wr(input logic sel, input logic [1:0] addr, input logic [47:0] data);
      wr_en   = 1'b1;
      wr_sel  = sel;
      wr_addr = addr;
      wr_data = data;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic load_default();
      wr(1'b0, 2'd0, {6{8'h01}});
      wr(1'b0, 2'd1, {6{8'h02}});
      wr(1'b0, 2'd2, {6{8'h03}});
      wr(1'b1, 2'd0, 48'd2);
      wr(1'b1, 2'd1, 48'd3);
      wr(1'b1, 2'd2, 48'd4);
      exp_a[0] = {6{8'h01}}; exp_a[1] = {6{8'h02}}; exp_a[2] = {6{8'h03}};
      exp_b[0] = 8'd2;       exp_b[1] = 8'd3;       exp_b[2] = 8'd4;
   endtask

   // One complete job, checked cycle by cycle from cycle 1 to the done cycle.
   task automatic run_job(input string tag, input bit poke, input logic [47:0] res);
      start = 1'b1;
      tick();
      start = 1'b0;
      if (poke) begin
         wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 2'd0; wr_data = {6{8'hEE}};
      end
      for (int c = 1; c <= 8; c++) begin
         chk({tag, "_busy"},  64'(busy),       64'(c != 8));
         chk({tag, "_clear"}, 64'(mac_clear),  64'(c == 1));
         chk({tag, "_en"},    64'(vsm_enable), 64'(c >= 2 && c <= 4));
         chk({tag, "_a"},     64'(vsm_a), (c >= 2 && c <= 4) ? 64'(exp_a[c-2]) : 64'd0);
         chk({tag, "_b"},     64'(vsm_b), (c >= 2 && c <= 4) ? 64'(exp_b[c-2]) : 64'd0);
         chk({tag, "_done"},  64'(done),       64'(c == 8));
         if (c == 8) chk({tag, "_result"}, 64'(result), 64'(res));
         if (poke && c == 2) begin
            wr_sel = 1'b1; wr_addr = 2'd1; wr_data = 48'h77;
         end
         if (c == 6) result_in = ~res;
         if (c == 7) begin
            result_in = res;
            wr_en     = 1'b0;
         end
         if (c == 8) result_in = ~res;
         if (c < 8) tick();
      end
      tick();
      chk({tag, "_done_off"}, 64'(done), 64'd0);
      chk({tag, "_held"}, 64'(result), 64'(res));
   endtask

   initial begin
      bit seen_done;
      reset = 1'b1; wr_en = 1'b0; wr_sel = 1'b0; wr_addr = '0; wr_data = '0;
      start = 1'b0; result_in = '0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      result_in = {6{8'h5A}};
      repeat (5) tick();
      chk("idle_busy",   64'(busy),       64'd0);
      chk("idle_clear",  64'(mac_clear),  64'd0);
      chk("idle_en",     64'(vsm_enable), 64'd0);
      chk("idle_a",      64'(vsm_a),      64'd0);
      chk("idle_b",      64'(vsm_b),      64'd0);
      chk("idle_done",   64'(done),       64'd0);
      chk("idle_result", 64'(result),     64'd0);

      load_default();
      run_job("job1", 1'b0, {6{8'h14}});

      // start held high: done every 8 cycles, each job opened by mac_clear
      start = 1'b1;
      for (int c = 1; c <= 24; c++) begin
         tick();
         chk("b2b_done",  64'(done),      64'(c % 8 == 0));
         chk("b2b_clear", 64'(mac_clear), 64'(c % 8 == 1));
         if (c == 24) start = 1'b0;
      end
      tick();
      chk("b2b_stop", 64'(busy), 64'd0);

      wr(1'b0, 2'd3, {6{8'hFF}});
      wr(1'b1, 2'd3, 48'hFF);
      run_job("poke", 1'b1, {6{8'h21}});
      run_job("rerun", 1'b0, {6{8'h14}});

      // write and start in the same IDLE cycle: the job sees the new scalar
      wr_en = 1'b1; wr_sel = 1'b1; wr_addr = 2'd0; wr_data = 48'd9; start = 1'b1;
      tick();
      wr_en = 1'b0; start = 1'b0;
      tick();
      chk("same_en", 64'(vsm_enable), 64'd1);
      chk("same_b",  64'(vsm_b),      64'd9);
      chk("same_a",  64'(vsm_a),      64'(exp_a[0]));
      repeat (6) tick();
      chk("same_done", 64'(done), 64'd1);
      wr(1'b1, 2'd0, 48'd2);

      // reset in cycle 3 of a job
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      reset = 1'b1;
      #1;
      chk("rst_busy",   64'(busy),       64'd0);
      chk("rst_clear",  64'(mac_clear),  64'd0);
      chk("rst_en",     64'(vsm_enable), 64'd0);
      chk("rst_a",      64'(vsm_a),      64'd0);
      chk("rst_b",      64'(vsm_b),      64'd0);
      chk("rst_done",   64'(done),       64'd0);
      chk("rst_result", 64'(result),     64'd0);
      @(negedge clk);
      reset = 1'b0;
      seen_done = 1'b0;
      for (int c = 0; c < 10; c++) begin
         tick();
         if (done) seen_done = 1'b1;
      end
      chk("rst_no_done", 64'(seen_done), 64'd0);

      exp_a[0] = '0; exp_a[1] = '0; exp_a[2] = '0;
      exp_b[0] = '0; exp_b[1] = '0; exp_b[2] = '0;
      run_job("cleared", 1'b0, {6{8'h3C}});
      load_default();
      run_job("post_rst", 1'b0, {6{8'h14}});

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
